// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StFix,
    StDone
  } state_e;

  // Iteration counter width for an arbitrary operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_acc_shift_reg.sv
// Accumulator/multiplier register pair {A,Q} for the shift-and-add multiplier.
// A is WIDTH+1 bits so the adder carry is kept until the shift absorbs it.
module mult_acc_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_m,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   w_sum;

  // Conditional add of the multiplicand when the current multiplier bit is set.
  always_comb begin
    w_sum = r_a;
    if (r_q[0]) w_sum = r_a + {1'b0, i_m};
  end

  // Load clears A and captures Q; a step adds then shifts {A,Q} right with a 0 in the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_q <= '0;
    end else if (i_load) begin
      r_a <= '0;
      r_q <= i_q;
    end else if (i_step) begin
      r_a <= {1'b0, w_sum[WIDTH:1]};
      r_q <= {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  assign o_a = r_a[WIDTH-1:0];
  assign o_q = r_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with start/done handshake.
// Optional build macro SIGNED_MULT_EN: two's-complement operands via sign/magnitude.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e             r_state;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;
`ifdef SIGNED_MULT_EN
  logic               r_sign;
`endif

  logic [WIDTH-1:0]   w_m_mag;
  logic [WIDTH-1:0]   w_q_mag;
  logic               w_sign;
  logic [WIDTH-1:0]   w_acc_a;
  logic [WIDTH-1:0]   w_acc_q;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_product;
  logic               w_load;
  logic               w_step;

  // Operand magnitudes, sign flag and final (optionally negated) product.
  always_comb begin
    w_raw = {w_acc_a, w_acc_q};
`ifdef SIGNED_MULT_EN
    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
    w_m_mag   = r_m[WIDTH-1] ? (~r_m + 1'b1) : r_m;
    w_q_mag   = r_q[WIDTH-1] ? (~r_q + 1'b1) : r_q;
    w_sign    = r_m[WIDTH-1] ^ r_q[WIDTH-1];
    w_product = r_sign ? (~w_raw + 1'b1) : w_raw;
`else
    w_m_mag   = r_m;
    w_q_mag   = r_q;
    w_sign    = 1'b0;
    w_product = w_raw;
`endif
  end

  assign w_load = (r_state == StLoad);
  assign w_step = (r_state == StCalc);

  mult_acc_shift_reg #(
    .WIDTH(WIDTH)
  ) u_acc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_m    (r_m),
    .i_q    (w_q_mag),
    .o_a    (w_acc_a),
    .o_q    (w_acc_q)
  );

  // Control FSM with registered busy/done/product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_m       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef SIGNED_MULT_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_m     <= i_multiplicand;
            r_q     <= i_multiplier;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          // r_m is reused for the magnitude; the accumulator takes Q's magnitude directly.
          r_m     <= w_m_mag;
`ifdef SIGNED_MULT_EN
          r_sign  <= w_sign;
`endif
          r_state <= StCalc;
        end
        StCalc: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(WIDTH - 1)) r_state <= StFix;
        end
        StFix: begin
          r_product <= w_product;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (either build of SIGNED_MULT_EN).
module tb_seq_shift_add_multiplier;

  localparam int W   = 8;
  localparam int LAT = W + 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl[7];

  seq_shift_add_multiplier #(
    .WIDTH(W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_multiplicand(mcand),
    .i_multiplier  (mplier),
    .o_busy        (busy),
    .o_done        (done),
    .o_product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer multiplication of the operands as the build interprets them.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
`ifdef SIGNED_MULT_EN
    p = int'($signed(m)) * int'($signed(q));
`else
    p = int'(m) * int'(q);
`endif
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction; operands are scrambled every cycle after the start edge.
  task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp);
    int lat;
    bit busy_ok;
    bit stable_ok;
    bit busy_at_done;
    logic [2*W-1:0] prev;
    @(negedge clk);
    prev   = product;
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    lat          = -1;
    busy_ok      = 1'b1;
    stable_ok    = 1'b1;
    busy_at_done = 1'b1;
    for (int k = 0; k < 30 && lat < 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      mcand  = W'($urandom);
      mplier = W'($urandom);
      if (done) begin
        lat          = k;
        busy_at_done = busy;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (product !== prev) stable_ok = 1'b0;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " busy window"}, {31'd0, busy_ok}, 32'd1);
    check({name, " busy at done"}, {31'd0, busy_at_done}, 32'd0);
    check({name, " product hold"}, {31'd0, stable_ok}, 32'd1);
    check({name, " product"}, 32'(product), 32'(exp));
    @(posedge clk);
    #1;
    check({name, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [2*W-1:0] seen;
    n_vec  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;

    tbl[0] = '{m: 8'd13,  q: 8'd11,  exp: 16'h008F};
    tbl[1] = '{m: 8'd0,   q: 8'd200, exp: 16'h0000};
    tbl[2] = '{m: 8'd6,   q: 8'd7,   exp: 16'h002A};
`ifdef SIGNED_MULT_EN
    tbl[3] = '{m: 8'hFF,  q: 8'hFF,  exp: 16'h0001};
    tbl[4] = '{m: 8'hF9,  q: 8'h05,  exp: 16'hFFDD};
    tbl[5] = '{m: 8'h80,  q: 8'h80,  exp: 16'h4000};
    tbl[6] = '{m: 8'h7F,  q: 8'h81,  exp: 16'hC0FF};
`else
    tbl[3] = '{m: 8'hFF,  q: 8'hFF,  exp: 16'hFE01};
    tbl[4] = '{m: 8'hF9,  q: 8'h05,  exp: 16'h04DD};
    tbl[5] = '{m: 8'h80,  q: 8'h80,  exp: 16'h4000};
    tbl[6] = '{m: 8'h7F,  q: 8'h81,  exp: 16'h3FFF};
`endif

    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].q, tbl[i].exp);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] m;
      logic [W-1:0] q;
      m = W'($urandom);
      q = W'($urandom);
      run_op($sformatf("rand%0d", i), m, q, model(m, q));
    end

    // A second start during CALC must be ignored.
    @(negedge clk);
    mcand  = 8'd6;
    mplier = 8'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mcand  = 8'd9;
    mplier = 8'd9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    seen  = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        seen = product;
      end
    end
    check("ignored start done count", 32'(dones), 32'd1);
    check("ignored start product", 32'(seen), 32'h002A);
    run_op("after ignored", 8'd9, 8'd9, 16'h0051);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    mcand  = 8'hAB;
    mplier = 8'h5D;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post reset", 8'd3, 8'd5, 16'h000F);

    // Start held high restarts on every return to IDLE.
    @(negedge clk);
    mcand  = 8'd12;
    mplier = 8'd13;
    start  = 1'b1;
    dones  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("held start done count", 32'(dones), 32'd3);
    check("held start product", 32'(product), 32'h009C);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
